// File: rtl/vga_timing_pkg.sv
// Shared timing presets and width helper for the VGA/HDMI timing generator family.
package vga_timing_pkg;

  localparam int unsigned P640_HACTIVE = 640;
  localparam int unsigned P640_HFP     = 16;
  localparam int unsigned P640_HSLEN   = 96;
  localparam int unsigned P640_HBP     = 48;
  localparam int unsigned P640_VACTIVE = 480;
  localparam int unsigned P640_VFP     = 10;
  localparam int unsigned P640_VSLEN   = 2;
  localparam int unsigned P640_VBP     = 33;
  localparam bit          P640_HPOL    = 1'b0;
  localparam bit          P640_VPOL    = 1'b0;

  localparam int unsigned P720_HACTIVE = 1280;
  localparam int unsigned P720_HFP     = 110;
  localparam int unsigned P720_HSLEN   = 40;
  localparam int unsigned P720_HBP     = 220;
  localparam int unsigned P720_VACTIVE = 720;
  localparam int unsigned P720_VFP     = 5;
  localparam int unsigned P720_VSLEN   = 5;
  localparam int unsigned P720_VBP     = 20;
  localparam bit          P720_HPOL    = 1'b1;
  localparam bit          P720_VPOL    = 1'b1;

  // Minimum width of 1 so a SCALE=1 phase counter still has a legal vector.
  function automatic int unsigned clog2w(input int unsigned v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping position counter, sync/active decode and an
// integer-scale phase sub-counter producing the source coordinate.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned W          = 11,
  parameter int unsigned TOTAL      = 800,
  parameter int unsigned ACTIVE     = 640,
  parameter int unsigned SYNC_START = 656,
  parameter int unsigned SYNC_LEN   = 96,
  parameter bit          POL        = 1'b0,
  parameter int unsigned SCALE      = 2
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         step_i,
  output logic [W-1:0] cnt_o,
  output logic         wrap_o,
  output logic         active_d_o,
  output logic         sync_o,
  output logic         ph_last_o,
  output logic [W-1:0] src_o
);

  localparam int unsigned PH_W = clog2w(SCALE);
  localparam logic [W-1:0]    LAST    = W'(TOTAL - 1);
  localparam logic [W-1:0]    ACT     = W'(ACTIVE);
  localparam logic [W-1:0]    S0      = W'(SYNC_START);
  localparam logic [W-1:0]    S1      = W'(SYNC_START + SYNC_LEN);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(SCALE - 1);

  logic [W-1:0]    cnt_q, cnt_d, src_q, src_d;
  logic [PH_W-1:0] ph_q, ph_d;
  logic            sync_q, sync_d, in_sync;

  always_comb begin
    cnt_d = cnt_q;
    ph_d  = ph_q;
    src_d = src_q;
    if (step_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
      // Phase and source coordinate hold through blanking, restart at position 0.
      if (cnt_d == '0) begin
        ph_d  = '0;
        src_d = '0;
      end else if (cnt_d < ACT) begin
        if (ph_q == PH_LAST) begin
          ph_d  = '0;
          src_d = src_q + W'(1);
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
    end
    in_sync = (cnt_d >= S0) && (cnt_d < S1);
    sync_d  = POL ? in_sync : ~in_sync;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q  <= LAST;
      ph_q   <= '0;
      src_q  <= '0;
      sync_q <= ~POL;
    end else begin
      cnt_q  <= cnt_d;
      ph_q   <= ph_d;
      src_q  <= src_d;
      sync_q <= sync_d;
    end
  end

  assign cnt_o      = cnt_q;
  assign wrap_o     = (cnt_q == LAST);
  assign active_d_o = (cnt_d < ACT);
  assign sync_o     = sync_q;
  assign ph_last_o  = (ph_q == PH_LAST);
  assign src_o      = src_q;

endmodule

// File: rtl/vga_timing_gen_scaled.sv
// Pixel timing generator with integer-upscale source coordinates and a
// per-source-row prefetch request for the line buffer.
module vga_timing_gen_scaled
  import vga_timing_pkg::*;
#(
  parameter int unsigned HACTIVE = P640_HACTIVE,
  parameter int unsigned HFP     = P640_HFP,
  parameter int unsigned HSLEN   = P640_HSLEN,
  parameter int unsigned HBP     = P640_HBP,
  parameter int unsigned VACTIVE = P640_VACTIVE,
  parameter int unsigned VFP     = P640_VFP,
  parameter int unsigned VSLEN   = P640_VSLEN,
  parameter int unsigned VBP     = P640_VBP,
  parameter bit          HPOL    = P640_HPOL,
  parameter bit          VPOL    = P640_VPOL,
  parameter int unsigned SCALE   = 2,
  parameter int unsigned CNT_W   = 11,
  parameter int unsigned FCNT_W  = 16
) (
  input  logic              pclk,
  input  logic              reset_n,
  input  logic              enable,
  output logic [CNT_W-1:0]  out_hcnt,
  output logic [CNT_W-1:0]  out_vcnt,
  output logic              out_hsync,
  output logic              out_vsync,
  output logic              out_blank,
  output logic              out_de,
  output logic [CNT_W-1:0]  out_src_x,
  output logic [CNT_W-1:0]  out_src_y,
  output logic              out_frame_start,
  output logic              out_line_start,
  output logic              out_line_req,
  output logic [CNT_W-1:0]  out_req_y,
  output logic [FCNT_W-1:0] out_frame_cnt
);

  localparam int unsigned HTOTAL = HACTIVE + HFP + HSLEN + HBP;
  localparam int unsigned VTOTAL = VACTIVE + VFP + VSLEN + VBP;
  localparam logic [CNT_W-1:0] HREQ_PRE = CNT_W'(HACTIVE - 1);
  localparam logic [CNT_W-1:0] VLAST    = CNT_W'(VTOTAL - 1);
  localparam logic [CNT_W-1:0] VACT_M1  = CNT_W'(VACTIVE - 1);

  if (SCALE < 1 || SCALE > 8) begin : g_bad_scale
    $error("vga_timing_gen_scaled: SCALE must be in 1..8");
  end
  if (HTOTAL >= (1 << CNT_W) || VTOTAL >= (1 << CNT_W)) begin : g_bad_width
    $error("vga_timing_gen_scaled: HTOTAL/VTOTAL do not fit in CNT_W");
  end
  if ((HACTIVE % SCALE) != 0 || (VACTIVE % SCALE) != 0) begin : g_bad_div
    $error("vga_timing_gen_scaled: active size not a multiple of SCALE");
  end

  logic h_wrap, v_wrap, h_act_d, v_act_d, v_ph_last, unused_h_ph_last;

  vga_axis_counter #(
    .W(CNT_W), .TOTAL(HTOTAL), .ACTIVE(HACTIVE), .SYNC_START(HACTIVE + HFP),
    .SYNC_LEN(HSLEN), .POL(HPOL), .SCALE(SCALE)
  ) u_h (
    .clk_i(pclk), .rst_n_i(reset_n), .step_i(enable),
    .cnt_o(out_hcnt), .wrap_o(h_wrap), .active_d_o(h_act_d), .sync_o(out_hsync),
    .ph_last_o(unused_h_ph_last), .src_o(out_src_x)
  );

  vga_axis_counter #(
    .W(CNT_W), .TOTAL(VTOTAL), .ACTIVE(VACTIVE), .SYNC_START(VACTIVE + VFP),
    .SYNC_LEN(VSLEN), .POL(VPOL), .SCALE(SCALE)
  ) u_v (
    .clk_i(pclk), .rst_n_i(reset_n), .step_i(enable & h_wrap),
    .cnt_o(out_vcnt), .wrap_o(v_wrap), .active_d_o(v_act_d), .sync_o(out_vsync),
    .ph_last_o(v_ph_last), .src_o(out_src_y)
  );

  logic              blank_q, blank_d, de_q, de_d;
  logic              fs_q, fs_d, ls_q, ls_d, lr_q, lr_d;
  logic [CNT_W-1:0]  req_y_q, req_y_d;
  logic [FCNT_W-1:0] fc_q, fc_d;

  always_comb begin
    ls_d    = enable & h_wrap;
    fs_d    = ls_d & v_wrap;
    blank_d = ~(h_act_d & v_act_d);
    de_d    = h_act_d & v_act_d;
    fc_d    = fs_d ? fc_q + FCNT_W'(1) : fc_q;
    lr_d    = 1'b0;
    req_y_d = req_y_q;
    // Next edge lands on hcnt==HACTIVE; the line does not change there, so the
    // current row's phase tells whether the following row starts a new source row.
    if (enable && out_hcnt == HREQ_PRE) begin
      if (out_vcnt == VLAST) begin
        lr_d    = 1'b1;
        req_y_d = '0;
      end else if (out_vcnt < VACT_M1 && v_ph_last) begin
        lr_d    = 1'b1;
        req_y_d = out_src_y + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      blank_q <= 1'b1;
      de_q    <= 1'b0;
      fs_q    <= 1'b0;
      ls_q    <= 1'b0;
      lr_q    <= 1'b0;
      req_y_q <= '0;
      fc_q    <= '0;
    end else begin
      blank_q <= blank_d;
      de_q    <= de_d;
      fs_q    <= fs_d;
      ls_q    <= ls_d;
      lr_q    <= lr_d;
      req_y_q <= req_y_d;
      fc_q    <= fc_d;
    end
  end

  assign out_blank       = blank_q;
  assign out_de          = de_q;
  assign out_frame_start = fs_q;
  assign out_line_start  = ls_q;
  assign out_line_req    = lr_q;
  assign out_req_y       = req_y_q;
  assign out_frame_cnt   = fc_q;

endmodule
